// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard.
//
// Register 0 is hardwired to zero and never holds a busy bit. Writes land on
// the rising edge; among enabled write ports targeting the same register the
// highest-numbered port wins. Reads are purely combinational. With BYPASS != 0
// a read sees same-cycle write data. The scoreboard marks registers with a
// pending producer: reserve sets, write clears, flush clears everything.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset (data and busy cleared)
//   rd_addr_i   NRD packed read addresses, port p at [p*AW +: AW]
//   rd_data_o   NRD packed read data, port p at [p*XLEN +: XLEN]
//   rd_busy_o   registered busy bit of each read port's addressed register
//   wr_en_i     per-write-port enable
//   wr_addr_i   NWR packed write addresses
//   wr_data_i   NWR packed write data
//   rsv_en_i    reserve request, marks rsv_addr_i busy
//   rsv_addr_i  register to reserve
//   flush_i     clear every busy bit; register contents kept
//   busy_vec_o  registered busy bit per register
module regfile_mp #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                rsv_en_i,
    input  logic [AW-1:0]       rsv_addr_i,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_vec_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Unpacked views of the write ports; wr_act excludes writes to x0.
    logic [AW-1:0]   wr_addr [NWR];
    logic [XLEN-1:0] wr_data [NWR];
    logic [NWR-1:0]  wr_act;

    always_comb begin
        wr_act = '0;
        for (int w = 0; w < NWR; w++) begin
            wr_addr[w] = wr_addr_i[w*AW +: AW];
            wr_data[w] = wr_data_i[w*XLEN +: XLEN];
            wr_act[w]  = wr_en_i[w] && (wr_addr[w] != '0);
        end
    end

    // Next state. Ports are visited in ascending order so the highest-numbered
    // matching port overwrites the others. Reserve is applied after the write
    // clears so a new producer wins over a retiring one; flush overrides both.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_act[w]) begin
                regs_d[wr_addr[w]] = wr_data[w];
                busy_d[wr_addr[w]] = 1'b0;
            end
        end
        if (rsv_en_i && (rsv_addr_i != '0)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read side: stored value, optionally overridden by same-cycle write data.
    logic [AW-1:0]   rd_addr [NRD];
    logic [XLEN-1:0] rd_val  [NRD];

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_addr[p] = rd_addr_i[p*AW +: AW];
            rd_val[p]  = regs_q[rd_addr[p]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_act[w] && (wr_addr[w] == rd_addr[p])) begin
                        rd_val[p] = wr_data[w];
                    end
                end
            end
            if (rd_addr[p] == '0) begin
                rd_val[p] = '0;
            end
            rd_data_o[p*XLEN +: XLEN] = rd_val[p];
            rd_busy_o[p]              = busy_q[rd_addr[p]];
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
    logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
    logic [NREGS-1:0]    busy_vec_b1, busy_vec_b0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b1),
        .rd_busy_o(rd_busy_b1), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .flush_i(flush), .busy_vec_o(busy_vec_b1)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b0),
        .rd_busy_o(rd_busy_b0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .flush_i(flush), .busy_vec_o(busy_vec_b0)
    );

    // Reference model: architectural contents and busy flags.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    bit              chk_on = 1'b0;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] waddr(int w);
        logic [NWR*AW-1:0] v;
        v = wr_addr;
        return v[w*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] wdata(int w);
        logic [NWR*XLEN-1:0] v;
        v = wr_data;
        return v[w*XLEN +: XLEN];
    endfunction

    // What a read of address a must return this cycle.
    function automatic logic [XLEN-1:0] exp_read(logic [AW-1:0] a, bit bypass);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (bypass) begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && waddr(w) == a) v = wdata(w);
        end
        return v;
    endfunction

    // Applies the architectural effect of the inputs present at this edge.
    task automatic model_update();
        bit written [NREGS];
        if (rst) begin
            for (int a = 0; a < NREGS; a++) begin
                m_mem[a]  = '0;
                m_busy[a] = 1'b0;
            end
            return;
        end
        for (int a = 0; a < NREGS; a++) written[a] = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && waddr(w) != 0) begin
                m_mem[waddr(w)]   = wdata(w);
                written[waddr(w)] = 1'b1;
            end
        end
        for (int a = 1; a < NREGS; a++) begin
            if (flush)                         m_busy[a] = 1'b0;
            else if (rsv_en && rsv_addr == a)  m_busy[a] = 1'b1;
            else if (written[a])               m_busy[a] = 1'b0;
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [NREGS-1:0] bv;
            logic [AW-1:0]    ra;
            bv = '0;
            for (int a = 0; a < NREGS; a++) bv[a] = m_busy[a];
            check("busy_vec_b1", XLEN'(busy_vec_b1), XLEN'(bv));
            check("busy_vec_b0", XLEN'(busy_vec_b0), XLEN'(bv));
            for (int p = 0; p < NRD; p++) begin
                ra = rd_addr[p*AW +: AW];
                check("rd_data_b1", rd_data_b1[p*XLEN +: XLEN], exp_read(ra, 1'b1));
                check("rd_data_b0", rd_data_b0[p*XLEN +: XLEN], exp_read(ra, 1'b0));
                check("rd_busy_b1", XLEN'(rd_busy_b1[p]), XLEN'(ra != 0 && m_busy[ra]));
                check("rd_busy_b0", XLEN'(rd_busy_b0[p]), XLEN'(ra != 0 && m_busy[ra]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*AW +: AW] = a;
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_rd('0, '0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_on = 1'b1;

        // Every address reads zero and idle after reset.
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a), AW'(NREGS - 1 - a));
            mid();
            check("rst_data_p0", rd_data_b1[0 +: XLEN], '0);
            check("rst_data_p1", rd_data_b0[XLEN +: XLEN], '0);
            check("rst_busy", XLEN'(rd_busy_b1), '0);
            tick();
        end
        check("rst_busy_vec", XLEN'(busy_vec_b1), '0);

        // Same-cycle bypass vs. registered read.
        set_wr(0, 5, 64'hDEADBEEF_CAFEF00D);
        set_rd(5, 5);
        mid();
        check("byp_p0", rd_data_b1[0 +: XLEN], 64'hDEADBEEF_CAFEF00D);
        check("byp_p1", rd_data_b1[XLEN +: XLEN], 64'hDEADBEEF_CAFEF00D);
        check("nobyp_p0", rd_data_b0[0 +: XLEN], 64'h0);
        tick();
        idle();
        mid();
        check("after_b1", rd_data_b1[XLEN +: XLEN], 64'hDEADBEEF_CAFEF00D);
        check("after_b0", rd_data_b0[0 +: XLEN], 64'hDEADBEEF_CAFEF00D);
        tick();

        // Write collision: port 1 wins.
        set_wr(0, 7, 64'h11);
        set_wr(1, 7, 64'h22);
        set_rd(7, 7);
        mid();
        check("coll_byp", rd_data_b1[0 +: XLEN], 64'h22);
        tick();
        idle();
        mid();
        check("coll_stored", rd_data_b0[XLEN +: XLEN], 64'h22);
        tick();

        // x0 ignores writes and reserves.
        set_wr(0, 0, 64'hFFFF);
        rsv_en = 1'b1; rsv_addr = 0;
        set_rd(0, 0);
        mid();
        check("x0_byp", rd_data_b1[0 +: XLEN], 64'h0);
        tick();
        idle();
        mid();
        check("x0_read", rd_data_b0[0 +: XLEN], 64'h0);
        check("x0_busy", XLEN'(busy_vec_b1[0]), 64'h0);
        tick();

        // Reserve, reserve+write (stays busy), write-only clears.
        rsv_en = 1'b1; rsv_addr = 3;
        set_rd(3, 3);
        tick();
        idle();
        mid();
        check("rsv3_busy", XLEN'(rd_busy_b1), 64'h3);
        set_wr(1, 3, 64'h33);
        rsv_en = 1'b1; rsv_addr = 3;
        tick();
        idle();
        mid();
        check("rsv3_still", XLEN'(rd_busy_b0), 64'h3);
        check("rsv3_data", rd_data_b0[0 +: XLEN], 64'h33);
        set_wr(0, 3, 64'h44);
        tick();
        idle();
        mid();
        check("rsv3_clear", XLEN'(rd_busy_b1), 64'h0);
        tick();

        // Reservations then flush (with competing reserve), then reset.
        for (int k = 0; k < 2; k++) begin
            rsv_en = 1'b1; rsv_addr = 4;  tick();
            rsv_addr = 9;  tick();
            rsv_addr = 12; tick();
            idle();
            mid();
            check("rsv_vec", XLEN'(busy_vec_b1), 64'h1210);
            rsv_en = 1'b1; rsv_addr = 15;
            if (k == 0) flush = 1'b1;
            else        rst   = 1'b1;
            tick();
            idle();
            set_rd(5, 7);
            mid();
            check("clr_vec", XLEN'(busy_vec_b1), 64'h0);
            check("clr_x5", rd_data_b1[0 +: XLEN], k == 0 ? 64'hDEADBEEF_CAFEF00D : 64'h0);
            check("clr_x7", rd_data_b0[XLEN +: XLEN], k == 0 ? 64'h22 : 64'h0);
            tick();
        end

        // Randomized traffic; narrow address range half the time for collisions.
        for (int i = 0; i < 4000; i++) begin
            logic [AW-1:0] mask;
            idle();
            mask = ($urandom_range(0, 1) == 0) ? AW'(7) : AW'(31);
            for (int w = 0; w < NWR; w++) begin
                if ($urandom_range(0, 2) != 0)
                    set_wr(w, AW'($urandom) & mask, {$urandom, $urandom});
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom) & mask;
            flush    = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            set_rd(AW'($urandom) & mask, AW'($urandom) & mask);
            tick();
        end

        idle();
        tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
